mdu_iter: RTL and testbench

// - Iterative multiply/divide unit. Next-generation companion to the single-cycle ALU.
// - Executes MIPS mult/multu/div/divu in WIDTH+2 cycles.
// - Uses a start/busy/done handshake and holds the result in HI/LO registers.
// - Sits beside the ALU in the datapath. The controller stalls while busy=1 and reads hi/lo (mfhi/mflo).

---
 rtl/mdu_iter.sv | 210 +++++++++++++++++++++
 tb/tb_mdu_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter : iterative multiply / divide unit (MIPS mult, multu, div, divu)
//
// - One operand bit per cycle: shift-add multiply, restoring divide.
// - Sequence IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
// - start is accepted in IDLE only. done is a one-cycle pulse in the DONE
//   state, and hi/lo/divzero become valid in that same cycle. A start held
//   high issues one operation every WIDTH+3 cycles.
// - Optional feature macro: MDU_SIGNED_EN
//     defined   : op[0]=1 selects signed (two's complement) mult/div
//     undefined : op[0] is ignored and every op is unsigned; the FIX state
//                 is still traversed, so latency is identical
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's complement negation of a single-width word
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of a double-width product
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Control and datapath state
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_b_mag;    // multiplicand / divisor magnitude
    logic                 r_is_div;
    logic                 r_dz;       // division with srcb == 0
    logic                 r_neg_q;    // product / quotient must be negated
    logic                 r_neg_r;    // remainder takes the dividend sign
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_divzero;

    // Operand preparation
    logic                 w_signed_op;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    // One iteration step
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Sign-corrected results
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;
    logic                 w_fix_dz;

`ifdef MDU_SIGNED_EN
    assign w_signed_op = op[0];
`else
    // op[0] is deliberately ignored: every operation is unsigned
    assign w_signed_op = op[0] & 1'b0;
`endif

    assign w_sign_a = w_signed_op & srca[WIDTH-1];
    assign w_sign_b = w_signed_op & srcb[WIDTH-1];
    // The magnitude of MIN is MIN itself read as unsigned, which is exact
    assign w_a_mag  = w_sign_a ? neg_w(srca) : srca;
    assign w_b_mag  = w_sign_b ? neg_w(srcb) : srcb;

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
        w_div_diff  = w_div_shift - {1'b0, r_b_mag};
        if (r_is_div) begin
            if (w_div_ge) begin
                w_acc_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                // Trial subtract failed, so the shifted remainder still fits in WIDTH bits
                w_acc_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero result selection
    always_comb begin
        w_prod   = r_neg_q ? neg_2w(r_acc) : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        w_fix_dz = 1'b0;
        if (r_is_div) begin
            // Remainder takes the dividend sign. For a zero divisor every trial
            // subtract succeeds, so the remainder half holds |srca| and this same
            // correction gives back srca unmodified.
            w_fix_hi = r_neg_r ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
            if (r_dz) begin
                w_fix_lo = {WIDTH{1'b1}};
                w_fix_dz = 1'b1;
            end else begin
                w_fix_lo = r_neg_q ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
                w_fix_dz = 1'b0;
            end
        end else begin
            w_fix_dz = 1'b0;
        end
    end

    // Sequencer, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_b_mag   <= {WIDTH{1'b0}};
            r_is_div  <= 1'b0;
            r_dz      <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Multiply and divide share the same starting layout
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b_mag  <= w_b_mag;
                        r_is_div <= op[1];
                        r_dz     <= op[1] & (srcb == {WIDTH{1'b0}});
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt   <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    r_hi      <= w_fix_hi;
                    r_lo      <= w_fix_lo;
                    r_divzero <= w_fix_dz;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    // start is ignored here; it is honoured from IDLE only
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign divzero = r_divzero;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter : directed self-checking bench for mdu_iter (WIDTH=32 and 8).
// Expected values are hand-computed; signed cases follow MDU_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divzero;

    logic        s8_start;
    logic [1:0]  s8_op;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic        s8_busy;
    logic        s8_done;
    logic [7:0]  s8_hi;
    logic [7:0]  s8_lo;
    logic        s8_divzero;

    int n_cmp = 0;
    int n_mis = 0;
    int got_lat;
    logic got_busy;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .divzero(divzero)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8_start), .op(s8_op),
        .srca(s8_a), .srcb(s8_b), .busy(s8_busy), .done(s8_done),
        .hi(s8_hi), .lo(s8_lo), .divzero(s8_divzero)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 32-bit unit and wait (bounded) for its done pulse
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got_busy = busy;
        srca = ~a;  // operands need not be held after acceptance
        srcb = ~b;
        got_lat = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                got_lat = i;
                break;
            end
        end
    endtask

    initial begin
        int ndone;
        int gap;
        logic [31:0] cap_lo;
        logic [31:0] cap_hi;

        reset_n = 1'b0; start = 1'b0; op = 2'd0; srca = 32'd0; srcb = 32'd0;
        s8_start = 1'b0; s8_op = 2'd0; s8_a = 8'd0; s8_b = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_busy", {63'd0, busy}, 64'd0);
        chk_val("rst_done", {63'd0, done}, 64'd0);
        chk_val("rst_hilo", {hi, lo}, 64'd0);
        chk_val("rst_dz", {63'd0, divzero}, 64'd0);
        reset_n = 1'b1;

        // multu max*max, with latency and handshake checks
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_val("multu_max_lat", got_lat, 64'd34);
        chk_val("multu_busy_after_start", {63'd0, got_busy}, 64'd1);
        chk_val("multu_busy_in_done", {63'd0, busy}, 64'd0);
        chk_val("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // mult -3*5
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5);
`ifdef MDU_SIGNED_EN
        chk_val("mult_m3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        chk_val("mult_m3x5", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

        // div -7/2
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
`ifdef MDU_SIGNED_EN
        chk_val("div_m7d2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        chk_val("div_m7d2", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif

        // divu 100/7
        run_op(2'b10, 32'd100, 32'd7);
        chk_val("divu_100d7", {hi, lo}, {32'd2, 32'd14});
        chk_val("divu_100d7_dz", {63'd0, divzero}, 64'd0);

        // MIN / -1
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MDU_SIGNED_EN
        chk_val("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
`else
        chk_val("div_min_m1", {hi, lo}, 64'h8000_0000_0000_0000);
`endif
        chk_val("div_min_m1_dz", {63'd0, divzero}, 64'd0);

        // divu by zero, then results hold while idle
        run_op(2'b10, 32'h0000_1234, 32'd0);
        chk_val("divu_z_lat", got_lat, 64'd34);
        chk_val("divu_z", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        chk_val("divu_z_dz", {63'd0, divzero}, 64'd1);
        repeat (5) @(negedge clk);
        chk_val("hold_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        chk_val("hold_dz", {63'd0, divzero}, 64'd1);

        // multu clears divzero
        run_op(2'b00, 32'd2, 32'd3);
        chk_val("multu_2x3", {hi, lo}, 64'd6);
        chk_val("multu_2x3_dz", {63'd0, divzero}, 64'd0);

        // div by zero with a negative dividend: hi is srca unmodified in both builds
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0);
        chk_val("div_neg_z", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
        chk_val("div_neg_z_dz", {63'd0, divzero}, 64'd1);

        // start re-pulsed while busy with other operands is ignored
        @(negedge clk);
        op = 2'b00; srca = 32'd6; srcb = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        srca = 32'd9; srcb = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; cap_lo = 32'hDEAD_BEEF; cap_hi = 32'hDEAD_BEEF;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap_lo = lo;
                cap_hi = hi;
            end
        end
        chk_val("busy_start_ndone", ndone, 64'd1);
        chk_val("busy_start_res", {cap_hi, cap_lo}, 64'd42);

        // start held high: back-to-back ops at WIDTH+3 cycle spacing
        @(negedge clk);
        op = 2'b00; srca = 32'd3; srcb = 32'd4; start = 1'b1;
        gap = 999;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                gap = i;
                break;
            end
        end
        start = 1'b0;
        chk_val("b2b_period", gap, 64'd35);
        chk_val("b2b_res", {hi, lo}, 64'd12);

        // reset mid-CALC aborts the op, no done pulse follows
        @(negedge clk);
        op = 2'b00; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_val("midrst_busy", {63'd0, busy}, 64'd0);
        chk_val("midrst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk_val("midrst_ndone", ndone, 64'd0);
        run_op(2'b10, 32'd100, 32'd7);
        chk_val("post_rst_divu", {hi, lo}, {32'd2, 32'd14});

        // WIDTH=8 instance: 0xFF*0xFF
        @(negedge clk);
        s8_op = 2'b00; s8_a = 8'hFF; s8_b = 8'hFF; s8_start = 1'b1;
        @(posedge clk);
        #1 s8_start = 1'b0;
        got_lat = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (s8_done) begin
                got_lat = i;
                break;
            end
        end
        chk_val("w8_lat", got_lat, 64'd10);
        chk_val("w8_multu", {48'd0, s8_hi, s8_lo}, 64'hFE01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
